// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES inverse-cipher sequencer.
//   state_t  : sequencer phases (IDLE, ARK, RND, DONE)
//   NR_*     : inverse-round counts for AES-128/192/256
//   BLOCK_W  : cipher block width in bits
package aes_dec_pkg;

  localparam int unsigned BLOCK_W = 128;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE,
    ARK,
    RND,
    DONE
  } state_t;

endpackage

// File: rtl/aes_dec_iter_ctrl.sv
// Sequencer for the iterative AES inverse cipher. Accepts one ciphertext
// block, applies the initial AddRoundKey and NR inverse rounds through an
// external combinational round unit, then presents the plaintext.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : ciphertext handshake, in_data byte 0 at [127:120]
//   out_valid/out_ready  : plaintext handshake, out_data same byte order
//   rk_addr / rk_data    : round-key RAM read port (1-cycle read latency)
//   rnd_state/rnd_last   : round-unit operands (state register, final-round flag)
//   rnd_out              : round-unit result
//   busy, round          : status / debug
module aes_dec_iter_ctrl
  import aes_dec_pkg::*;
#(
  parameter int unsigned NR     = NR_128,
  parameter int unsigned KEY_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic [KEY_AW-1:0]  rk_addr,
  input  logic [BLOCK_W-1:0] rk_data,
  output logic [BLOCK_W-1:0] rnd_state,
  output logic               rnd_last,
  input  logic [BLOCK_W-1:0] rnd_out,
  output logic               busy,
  output logic [KEY_AW-1:0]  round
);

  localparam logic [KEY_AW-1:0] ADDR_NR  = KEY_AW'(NR);
  localparam logic [KEY_AW-1:0] ADDR_NR1 = KEY_AW'(NR - 1);
  localparam logic [KEY_AW-1:0] ADDR_NR2 = KEY_AW'(NR - 2);

  state_t             fsm;
  logic [BLOCK_W-1:0] state_reg;

  assign rnd_state = state_reg;
  assign out_data  = state_reg;

  // The key address always runs one round ahead of the key being consumed,
  // because the RAM returns data one cycle after the address is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      state_reg <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rk_addr   <= ADDR_NR;
      round     <= ADDR_NR;
      busy      <= 1'b0;
      rnd_last  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_reg <= in_data;
            rk_addr   <= ADDR_NR1;
            round     <= ADDR_NR1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            fsm       <= ARK;
          end
        end
        ARK: begin
          state_reg <= state_reg ^ rk_data;
          rk_addr   <= ADDR_NR2;
          rnd_last  <= (round == '0);
          fsm       <= RND;
        end
        RND: begin
          state_reg <= rnd_out;
          if (round != '0) begin
            round    <= round - KEY_AW'(1);
            rk_addr  <= (round >= KEY_AW'(2)) ? round - KEY_AW'(2) : '0;
            // Registered so it is high exactly while round==0 in RND.
            rnd_last <= (round == KEY_AW'(1));
          end else begin
            rk_addr   <= ADDR_NR;
            rnd_last  <= 1'b0;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            round     <= ADDR_NR;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Self-checking bench for aes_dec_iter_ctrl: key RAM and golden inverse
// round unit modelled here; expected plaintexts are queued at issue time and
// compared by monitors whenever the DUT completes an output handshake.
module tb_aes_dec_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [127:0] in_data = '0, out_data, rk_data = '0, rnd_state, rnd_out;
  logic         rnd_last, busy;
  logic [3:0]   rk_addr, round;

  logic         in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
  logic [127:0] in_data_b = '0, out_data_b, rk_data_b = '0, rnd_state_b, rnd_out_b;
  logic         rnd_last_b, busy_b;
  logic [3:0]   rk_addr_b, round_b;

  aes_dec_iter_ctrl #(.NR(10), .KEY_AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rk_addr(rk_addr), .rk_data(rk_data), .rnd_state(rnd_state), .rnd_last(rnd_last),
    .rnd_out(rnd_out), .busy(busy), .round(round));

  aes_dec_iter_ctrl #(.NR(14), .KEY_AW(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .rk_addr(rk_addr_b), .rk_data(rk_data_b), .rnd_state(rnd_state_b), .rnd_last(rnd_last_b),
    .rnd_out(rnd_out_b), .busy(busy_b), .round(round_b));

  always #5 clk = ~clk;

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox  [0:255];
  logic [7:0]   isbox [0:255];
  logic [31:0]  w     [0:59];
  logic [127:0] rk10  [0:10];
  logic [127:0] rk14  [0:14];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] isr(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] isb(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] imc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = isb(isr(s)) ^ k;
    return last ? t : imc(t);
  endfunction

  // Whole-block FIPS-197 InvCipher using the key schedule for nr rounds.
  function automatic logic [127:0] ref_dec(input logic [127:0] c, input int nr);
    logic [127:0] s;
    s = c ^ ((nr == 14) ? rk14[nr] : rk10[nr]);
    for (int r = nr - 1; r >= 1; r--)
      s = imc(isb(isr(s)) ^ ((nr == 14) ? rk14[r] : rk10[r]));
    return isb(isr(s)) ^ ((nr == 14) ? rk14[0] : rk10[0]);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Key RAM (1-cycle read latency) and golden round units.
  always @(posedge clk) begin
    rk_data   <= (rk_addr <= 4'd10) ? rk10[rk_addr] : '0;
    rk_data_b <= (rk_addr_b <= 4'd14) ? rk14[rk_addr_b] : '0;
  end
  assign rnd_out   = inv_round(rnd_state, rk_data, rnd_last);
  assign rnd_out_b = inv_round(rnd_state_b, rk_data_b, rnd_last_b);

  // ---------------- checking ----------------
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: bound expired before the awaited event", name);
  endtask

  logic [127:0] qa[$];
  logic [127:0] qb[$];
  int   cyc = 0;
  bit   inflight = 1'b0;
  int   acc_cyc = 0;
  int   acc_b = 0;
  int   last_acc = 0;
  bit   b2b = 1'b0;
  bit   b2b_seen = 1'b0;
  bit   stall_prev = 1'b0;
  logic [127:0] stall_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the NR=10 instance: timing expectations derived from the
  // accept cycle, data from the scoreboard queue.
  always @(negedge clk) begin : mon_a
    int k;
    int ea;
    if (rst) begin
      inflight   = 1'b0;
      stall_prev = 1'b0;
      qa.delete();
    end else begin
      k = cyc - acc_cyc;
      chki("in_ready", int'(in_ready), inflight ? 0 : 1);
      chki("busy", int'(busy), inflight ? 1 : 0);
      if (inflight) begin
        ea = (k >= 12) ? 10 : ((10 - k > 0) ? 10 - k : 0);
        chki("rk_addr", int'(rk_addr), ea);
        chki("rnd_last", int'(rnd_last), (k == 11) ? 1 : 0);
        chki("out_valid", int'(out_valid), (k >= 12) ? 1 : 0);
      end else begin
        chki("idle_out_valid", int'(out_valid), 0);
        chki("idle_rnd_last", int'(rnd_last), 0);
        chki("idle_rk_addr", int'(rk_addr), 10);
      end
      if (stall_prev) chk("out_hold", out_data, stall_data);
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          $display("FAIL out_unexpected: got %h expected no output", out_data);
        end else begin
          chk("out_data", out_data, qa.pop_front());
        end
        inflight = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (b2b) begin
          if (b2b_seen) chki("accept_spacing", cyc - last_acc, 13);
          b2b_seen = 1'b1;
        end
        last_acc = cyc;
        acc_cyc  = cyc;
        inflight = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : mon_b
    if (!rst) begin
      if (in_valid_b && in_ready_b) acc_b = cyc;
      if (out_valid_b && out_ready_b) begin
        if (qb.size() == 0) begin
          checks++;
          $display("FAIL out_b_unexpected: got %h expected no output", out_data_b);
        end else begin
          chk("out_data_b", out_data_b, qb.pop_front());
        end
        chki("latency_b", cyc - acc_b, 16);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail(name);
  endtask

  task automatic send(input logic [127:0] d, input logic [127:0] exp);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    qa.push_back(exp);
    wait_accept("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rnd128();  // must not disturb the block in flight
  endtask

  task automatic wait_out_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail("out_valid_timeout");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0 && !out_valid && !out_valid_b) begin
        ok = 1'b1; break;
      end
    end
    if (!ok) fail("drain_timeout");
  endtask

  task automatic send_b(input logic [127:0] d, input logic [127:0] exp);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid_b = 1'b1;
    in_data_b  = d;
    qb.push_back(exp);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready_b) begin ok = 1'b1; break; end
    end
    if (!ok) fail("accept_b_timeout");
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    in_data_b  = rnd128();
  endtask

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [127:0] d;
    bit ok;
    init_sbox();
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_data", out_data, '0);
    chk("rst_rnd_state", rnd_state, '0);
    chki("rst_round", int'(round), 10);
    chki("rst_rk_addr", int'(rk_addr), 10);
    chki("rst_in_ready", int'(in_ready), 1);
    chki("rst_out_valid", int'(out_valid), 0);

    // FIPS-197 C.1 known answer
    send(C1_CT, PT);
    wait_idle();

    // random blocks with random consumer back-pressure
    for (int n = 0; n < 4; n++) begin
      d = rnd128();
      out_ready = 1'b0;
      send(d, ref_dec(d, 10));
      wait_out_valid();
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_idle();
    end

    // long stall with a second block waiting upstream
    out_ready = 1'b0;
    d = rnd128();
    send(d, ref_dec(d, 10));
    d = rnd128();
    in_valid = 1'b1;
    in_data  = d;
    qa.push_back(ref_dec(d, 10));
    wait_out_valid();
    repeat (20) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept("stall_accept_timeout");
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle();

    // back-to-back: in_valid held high across three blocks
    b2b_seen = 1'b0;
    b2b = 1'b1;
    @(posedge clk); #1 in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      d = rnd128();
      in_data = d;
      qa.push_back(ref_dec(d, 10));
      wait_accept("b2b_accept_timeout");
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    wait_idle();

    // reset in the middle of a block
    d = rnd128();
    send(d, ref_dec(d, 10));
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (round == 4'd5 && busy) begin ok = 1'b1; break; end
    end
    if (!ok) fail("round5_timeout");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chki("abort_in_ready", int'(in_ready), 1);
    chki("abort_out_valid", int'(out_valid), 0);
    chki("abort_busy", int'(busy), 0);
    d = rnd128();
    send(d, ref_dec(d, 10));
    wait_idle();

    // NR=14 instance: FIPS-197 C.3 then random blocks
    send_b(C3_CT, PT);
    wait_idle();
    for (int n = 0; n < 2; n++) begin
      d = rnd128();
      send_b(d, ref_dec(d, 14));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
